// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use stall, branch flush, EX operand forwarding,
// plus free-running stall/flush event counters.
module hazard_ctrl #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic            id_usesrs,
    input  logic            id_usesrt,
    input  logic [4:0]      ex_rs,
    input  logic [4:0]      ex_rt,
    input  logic [4:0]      ex_writereg,
    input  logic            ex_regwriteen,
    input  logic            ex_memtoreg,
    input  logic [4:0]      mem_writereg,
    input  logic            mem_regwriteen,
    input  logic            mem_memtoreg,
    input  logic            mem_link,
    input  logic [4:0]      wb_writereg,
    input  logic            wb_regwriteen,
    input  logic            mem_pcsrc,
    output logic            hazard,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic [1:0]      fwda,
    output logic [1:0]      fwdb,
    output logic [CNTW-1:0] stall_count,
    output logic [CNTW-1:0] flush_count
);

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] LDSTALL = 1'b1;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    logic [0:0] state;
    logic [0:0] state_next;
    logic       ex_load;
    logic       rs_dep;
    logic       rt_dep;
    logic       loaduse;
    logic       stall;
    logic       mem_fwd_ok;
    logic       wb_fwd_ok;

    // A load in EX whose destination is read by ID; suppressed while the
    // single stall bubble is already in flight.
    always_comb begin
        ex_load = ex_memtoreg & ex_regwriteen & (ex_writereg != 5'd0);
        rs_dep  = id_usesrs & (id_rs == ex_writereg);
        rt_dep  = id_usesrt & (id_rt == ex_writereg);
        loaduse = ex_load & (rs_dep | rt_dep) & (state == RUN);
        stall   = loaduse & ~mem_pcsrc;
    end

    always_comb begin
        hazard      = stall;
        idex_flush  = stall | mem_pcsrc;
        ifid_flush  = mem_pcsrc;
        exmem_flush = mem_pcsrc;
    end

    always_comb begin
        state_next = RUN;
        if (!mem_pcsrc && state == RUN && stall) begin
            state_next = LDSTALL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall) begin
                stall_count <= stall_count + 1'b1;
            end
            if (mem_pcsrc) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

    // MEM may only forward ALU results; loads and link writes come from WB.
    always_comb begin
        mem_fwd_ok = mem_regwriteen & (mem_writereg != 5'd0) & ~mem_memtoreg & ~mem_link;
        wb_fwd_ok  = wb_regwriteen & (wb_writereg != 5'd0);

        fwda = FWD_RF;
        if (mem_fwd_ok && mem_writereg == ex_rs) begin
            fwda = FWD_MEM;
        end else if (wb_fwd_ok && wb_writereg == ex_rs) begin
            fwda = FWD_WB;
        end

        fwdb = FWD_RF;
        if (mem_fwd_ok && mem_writereg == ex_rt) begin
            fwdb = FWD_MEM;
        end else if (wb_fwd_ok && wb_writereg == ex_rt) begin
            fwdb = FWD_WB;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus
// hand-written multi-cycle sequences for stall, flush, wrap and reset.
module tb_hazard_ctrl;

    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      id_rs, id_rt, ex_rs, ex_rt, ex_writereg, mem_writereg, wb_writereg;
    logic            id_usesrs, id_usesrt, ex_regwriteen, ex_memtoreg;
    logic            mem_regwriteen, mem_memtoreg, mem_link, wb_regwriteen, mem_pcsrc;
    logic            hazard, ifid_flush, idex_flush, exmem_flush;
    logic [1:0]      fwda, fwdb;
    logic [CNTW-1:0] stall_count, flush_count;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_usesrs(id_usesrs), .id_usesrt(id_usesrt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_writereg(ex_writereg),
        .ex_regwriteen(ex_regwriteen), .ex_memtoreg(ex_memtoreg),
        .mem_writereg(mem_writereg), .mem_regwriteen(mem_regwriteen),
        .mem_memtoreg(mem_memtoreg), .mem_link(mem_link),
        .wb_writereg(wb_writereg), .wb_regwriteen(wb_regwriteen),
        .mem_pcsrc(mem_pcsrc),
        .hazard(hazard), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .fwda(fwda), .fwdb(fwdb),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [4:0] id_rs;  logic [4:0] id_rt;  logic usesrs; logic usesrt;
        logic [4:0] ex_rs;  logic [4:0] ex_rt;
        logic [4:0] ex_wr;  logic ex_we;  logic ex_m2r;
        logic [4:0] mem_wr; logic mem_we; logic mem_m2r; logic mem_link;
        logic [4:0] wb_wr;  logic wb_we;  logic pcsrc;
        logic e_haz; logic e_ifid; logic e_idex; logic e_exmem;
        logic [1:0] e_fwda; logic [1:0] e_fwdb;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; id_usesrs = 0; id_usesrt = 0;
        ex_rs = '0; ex_rt = '0; ex_writereg = '0; ex_regwriteen = 0; ex_memtoreg = 0;
        mem_writereg = '0; mem_regwriteen = 0; mem_memtoreg = 0; mem_link = 0;
        wb_writereg = '0; wb_regwriteen = 0; mem_pcsrc = 0;
    endtask

    // lw $8 in EX, add reading $8 as rs in ID
    task automatic set_loaduse();
        ex_writereg = 5'd8; ex_regwriteen = 1; ex_memtoreg = 1;
        id_rs = 5'd8; id_usesrs = 1;
    endtask

    task automatic do_reset();
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic check_flags(input string name, input logic h, input logic f1,
                               input logic f2, input logic f3);
        check({name, "_hazard"}, int'(hazard), int'(h));
        check({name, "_ifid"},   int'(ifid_flush), int'(f1));
        check({name, "_idex"},   int'(idex_flush), int'(f2));
        check({name, "_exmem"},  int'(exmem_flush), int'(f3));
    endtask

    initial begin
        //         idrs idrt urs urt exrs exrt exwr we m2r mwr mwe mm2r lnk wbwr wwe pc  haz if id ex fa    fb
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
        vecs[1]  = '{8, 0, 1, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00};
        vecs[2]  = '{0, 9, 0, 1, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00};
        vecs[3]  = '{0, 9, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
        vecs[4]  = '{8, 0, 1, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
        vecs[5]  = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
        vecs[6]  = '{0, 0, 0, 0, 5, 3, 0, 0, 0, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00};
        vecs[7]  = '{0, 0, 0, 0, 5, 3, 0, 0, 0, 5, 1, 1, 0, 5, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00};
        vecs[8]  = '{0, 0, 0, 0, 5, 3, 0, 0, 0, 5, 1, 0, 1, 5, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00};
        vecs[9]  = '{0, 0, 0, 0, 7, 7, 0, 0, 0, 7, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 2'b10, 2'b10};
        vecs[10] = '{0, 0, 0, 0, 4, 4, 0, 0, 0, 6, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 2'b01, 2'b01};
        vecs[11] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00};
        vecs[12] = '{0, 0, 0, 0, 6, 1, 0, 0, 0, 6, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 2'b00, 2'b00};
        vecs[14] = '{8, 0, 1, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 2'b00, 2'b00};

        idle();
        reset = 1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state_stall_count", int'(stall_count), 0);
        check("reset_state_flush_count", int'(flush_count), 0);
        check_flags("reset_state", 0, 0, 0, 0);
        reset = 0;

        // Each vector is held only between edges so state stays RUN.
        foreach (vecs[i]) begin
            @(negedge clk);
            id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt;
            id_usesrs = vecs[i].usesrs; id_usesrt = vecs[i].usesrt;
            ex_rs = vecs[i].ex_rs; ex_rt = vecs[i].ex_rt;
            ex_writereg = vecs[i].ex_wr; ex_regwriteen = vecs[i].ex_we; ex_memtoreg = vecs[i].ex_m2r;
            mem_writereg = vecs[i].mem_wr; mem_regwriteen = vecs[i].mem_we;
            mem_memtoreg = vecs[i].mem_m2r; mem_link = vecs[i].mem_link;
            wb_writereg = vecs[i].wb_wr; wb_regwriteen = vecs[i].wb_we;
            mem_pcsrc = vecs[i].pcsrc;
            #1;
            check_flags($sformatf("vec%0d", i), vecs[i].e_haz, vecs[i].e_ifid,
                        vecs[i].e_idex, vecs[i].e_exmem);
            check($sformatf("vec%0d_fwda", i), int'(fwda), int'(vecs[i].e_fwda));
            check($sformatf("vec%0d_fwdb", i), int'(fwdb), int'(vecs[i].e_fwdb));
            idle();
        end
        check("table_no_count_stall", int'(stall_count), 0);
        check("table_no_count_flush", int'(flush_count), 0);

        // Load-use stall lasts exactly one cycle.
        do_reset();
        set_loaduse(); #1;
        check_flags("lu_c0", 1, 0, 1, 0);
        @(negedge clk); #1;
        check_flags("lu_c1_ldstall", 0, 0, 0, 0);
        check("lu_stall_count", int'(stall_count), 1);
        idle();
        @(negedge clk);
        set_loaduse(); #1;
        check("lu_back_in_run", int'(hazard), 1);
        idle();

        // Flush beats a simultaneous load-use.
        do_reset();
        set_loaduse(); mem_pcsrc = 1; #1;
        check_flags("flush_lu", 0, 1, 1, 1);
        @(negedge clk);
        idle(); #1;
        check("flush_lu_flush_count", int'(flush_count), 1);
        check("flush_lu_stall_count", int'(stall_count), 0);

        // Flush while in LDSTALL returns to RUN.
        do_reset();
        set_loaduse();
        @(negedge clk);
        mem_pcsrc = 1; #1;
        check_flags("flush_in_ldstall", 0, 1, 1, 1);
        @(negedge clk);
        mem_pcsrc = 0; #1;
        check("after_flush_run", int'(hazard), 1);
        idle();

        // Stall counter wraps at 2^CNTW.
        do_reset();
        for (int n = 0; n < 16; n++) begin
            set_loaduse();
            @(negedge clk);
            idle();
            @(negedge clk);
            if (n == 14) check("stall_count_15", int'(stall_count), 15);
        end
        #1;
        check("stall_count_wrap", int'(stall_count), 0);

        // Flush counter wraps too.
        do_reset();
        mem_pcsrc = 1;
        repeat (15) @(negedge clk);
        #1;
        check("flush_count_15", int'(flush_count), 15);
        @(negedge clk); #1;
        check("flush_count_wrap", int'(flush_count), 0);
        idle();

        // Reset asserted in LDSTALL clears everything asynchronously.
        do_reset();
        set_loaduse();
        @(negedge clk); #1;
        check("pre_reset_stall_count", int'(stall_count), 1);
        check("pre_reset_ldstall", int'(hazard), 0);
        reset = 1; #1;
        check("async_reset_stall_count", int'(stall_count), 0);
        check("reset_outputs_live", int'(hazard), 1);
        idle();
        @(negedge clk);
        reset = 0;
        @(negedge clk); #1;
        check("post_reset_hazard", int'(hazard), 0);
        check("post_reset_stall_count", int'(stall_count), 0);
        check("post_reset_flush_count", int'(flush_count), 0);
        set_loaduse(); #1;
        check("post_reset_run", int'(hazard), 1);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
